// File: rtl/ram_nrw_pkg.sv
// Shared definitions for the multi-port read/write RAM: init FSM states,
// the supported port-count ceiling and the address-width helper.
package ram_nrw_pkg;

    // Largest number of read/write ports the merge/collision logic is sized for.
    localparam int ram_nrw_max_ports_lp = 4;

    // Init sweep state: INIT walks the array, READY accepts user requests.
    typedef enum logic [0:0] {
        INIT  = 1'b0,
        READY = 1'b1
    } ram_nrw_state_e;

    // Address width that never collapses to zero bits for a one-entry array.
    function automatic int ram_nrw_safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_nrw_init_ctrl.sv
// Init sweep controller: after reset, writes one entry per cycle from 0 up
// to els_p-1, then raises ready_o and stays there until the next reset.
module ram_nrw_init_ctrl
    import ram_nrw_pkg::*;
#(
    parameter int els_p         = 16,
    parameter int addr_width_lp = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    output logic                     ready_o,
    output logic                     init_we_o,
    output logic [addr_width_lp-1:0] init_addr_o
);

    localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

    ram_nrw_state_e            state_q, state_d;
    logic [addr_width_lp-1:0]  cnt_q, cnt_d;

    // Next-state and outputs: sweep one entry per cycle, hand over to READY
    // in the cycle after the last entry is written.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we_o = 1'b0;
        ready_o   = 1'b0;
        case (state_q)
            INIT: begin
                init_we_o = 1'b1;
                if (cnt_q == last_addr_lp) begin
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            READY: begin
                ready_o = 1'b1;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign init_addr_o = cnt_q;

    // State register: reset restarts the sweep from entry 0 in any state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/ram_nrw_sync.sv
// Synchronous RAM with ports_p read/write ports, per-port bit-masked writes,
// write-first read data, deterministic write-write merging (higher port wins
// on overlapping mask bits) and same-cycle forwarding of the merged value.
// A hardware sweep fills the array with init_val_p after every reset.
// Optional build macro RAM_NRW_SYNC_OUTREG_EN adds one output register stage
// (read latency 2). sim_addr_check_p enables the simulation-only
// out-of-range address message.
module ram_nrw_sync
    import ram_nrw_pkg::*;
#(
    parameter int                width_p          = 32,
    parameter int                els_p            = 16,
    parameter int                ports_p          = 2,
    parameter int                addr_width_lp    = ram_nrw_safe_clog2(els_p),
    parameter logic [width_p-1:0] init_val_p      = '0,
    parameter bit                sim_addr_check_p = 1'b1
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    output logic                             ready_o,
    input  logic [ports_p-1:0]               v_i,
    input  logic [ports_p-1:0]               w_i,
    input  logic [ports_p*addr_width_lp-1:0] addr_i,
    input  logic [ports_p*width_p-1:0]       data_i,
    input  logic [ports_p*width_p-1:0]       w_mask_i,
    output logic [ports_p*width_p-1:0]       data_o,
    output logic [ports_p-1:0]               data_v_o,
    output logic                             ww_collision_o
);

    // One extra bit so els_p itself is representable for the range compare.
    localparam logic [addr_width_lp:0] els_lp = (addr_width_lp + 1)'(els_p);

    if (ports_p < 1 || ports_p > ram_nrw_max_ports_lp) begin : g_bad_ports
        $error("ram_nrw_sync: ports_p must be between 1 and %0d", ram_nrw_max_ports_lp);
    end

    // Storage is deliberately not reset: the init sweep defines its contents.
    logic [width_p-1:0]       mem_q [els_p];

    logic                     init_we;
    logic [addr_width_lp-1:0] init_addr;

    logic [addr_width_lp-1:0] addr   [ports_p];
    logic [width_p-1:0]       wdata  [ports_p];
    logic [width_p-1:0]       wmask  [ports_p];
    logic [width_p-1:0]       merged [ports_p];
    logic [ports_p-1:0]       in_range;
    logic [ports_p-1:0]       acc;
    logic [ports_p-1:0]       wr_acc;
    logic                     coll;

    logic [ports_p*width_p-1:0] data_q, data_d;
    logic [ports_p-1:0]         data_v_q, data_v_d;
    logic                       ww_coll_q, ww_coll_d;

    ram_nrw_init_ctrl #(
        .els_p         (els_p),
        .addr_width_lp (addr_width_lp)
    ) u_init_ctrl (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .ready_o     (ready_o),
        .init_we_o   (init_we),
        .init_addr_o (init_addr)
    );

    // Unpack the flat port buses and qualify each request. Requests are only
    // accepted once the sweep is done, and never in a reset cycle.
    for (genvar gi = 0; gi < ports_p; gi++) begin : g_port
        assign addr[gi]     = addr_i[gi*addr_width_lp +: addr_width_lp];
        assign wdata[gi]    = data_i[gi*width_p +: width_p];
        assign wmask[gi]    = w_mask_i[gi*width_p +: width_p];
        assign in_range[gi] = ({1'b0, addr[gi]} < els_lp);
        assign acc[gi]      = v_i[gi] & ready_o & ~reset_i;
        assign wr_acc[gi]   = acc[gi] & w_i[gi] & in_range[gi];
    end

    // Post-write value of each port's entry: start from the stored word and
    // fold in every write to the same address in ascending port order, so
    // the highest port wins on overlapping mask bits. Reads and writes of the
    // same entry therefore all see the fully merged value.
    always_comb begin
        for (int p = 0; p < ports_p; p++) begin
            merged[p] = in_range[p] ? mem_q[addr[p]] : '0;
            for (int q = 0; q < ports_p; q++) begin
                if (wr_acc[q] && (addr[q] == addr[p])) begin
                    merged[p] = (merged[p] & ~wmask[q]) | (wdata[q] & wmask[q]);
                end
            end
        end
    end

    // Flag any pair of accepted in-range writes that target the same entry.
    always_comb begin
        coll = 1'b0;
        for (int p = 0; p < ports_p; p++) begin
            for (int q = p + 1; q < ports_p; q++) begin
                if (wr_acc[p] && wr_acc[q] && (addr[p] == addr[q])) begin
                    coll = 1'b1;
                end
            end
        end
    end

    // Array update: sweep writes while initialising, user writes afterwards.
    // Colliding ports all carry the same merged word, so write order is moot.
    always_ff @(posedge clk_i) begin
        if (init_we) begin
            mem_q[init_addr] <= init_val_p;
        end
        for (int p = 0; p < ports_p; p++) begin
            if (wr_acc[p]) begin
                mem_q[addr[p]] <= merged[p];
            end
        end
    end

    // Read-data next state: accepted ports load the merged word, idle ports
    // hold their last value; valid simply follows acceptance.
    always_comb begin
        data_d    = data_q;
        data_v_d  = acc;
        ww_coll_d = coll;
        for (int p = 0; p < ports_p; p++) begin
            if (acc[p]) begin
                data_d[p*width_p +: width_p] = merged[p];
            end
        end
    end

    // First output stage: one cycle after the request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q    <= '0;
            data_v_q  <= '0;
            ww_coll_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            data_v_q  <= data_v_d;
            ww_coll_q <= ww_coll_d;
        end
    end

`ifdef RAM_NRW_SYNC_OUTREG_EN
    logic [ports_p*width_p-1:0] data_out_q;
    logic [ports_p-1:0]         data_v_out_q;
    logic                       ww_coll_out_q;

    // Extra unstalled retiming stage on all read-side outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_out_q    <= '0;
            data_v_out_q  <= '0;
            ww_coll_out_q <= 1'b0;
        end else begin
            data_out_q    <= data_q;
            data_v_out_q  <= data_v_q;
            ww_coll_out_q <= ww_coll_q;
        end
    end

    assign data_o         = data_out_q;
    assign data_v_o       = data_v_out_q;
    assign ww_collision_o = ww_coll_out_q;
`else
    assign data_o         = data_q;
    assign data_v_o       = data_v_q;
    assign ww_collision_o = ww_coll_q;
`endif

    if (sim_addr_check_p) begin : g_addr_check
        // Simulation aid: report accepted requests beyond the last entry.
        always_ff @(posedge clk_i) begin
            for (int p = 0; p < ports_p; p++) begin
                if (acc[p] && !in_range[p]) begin
                    $error("ram_nrw_sync: port %0d address %0d out of range", p, addr[p]);
                end
            end
        end
    end

endmodule

// File: tb/tb_ram_nrw_sync.sv
// Scoreboard bench for ram_nrw_sync (width 32, 12 entries, 3 ports).
// Every driven cycle pushes its expected outputs; they are popped and
// compared in the cycle the DUT is due to present them.
module tb_ram_nrw_sync;

    localparam int W   = 32;
    localparam int ELS = 12;
    localparam int P   = 3;
    localparam int AW  = 4;
    localparam logic [W-1:0] INIT_VAL = 32'hA5A5A5A5;
`ifdef RAM_NRW_SYNC_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             ready_o;
    logic [P-1:0]     v_i, w_i, data_v_o;
    logic [P*AW-1:0]  addr_i;
    logic [P*W-1:0]   data_i, w_mask_i, data_o;
    logic             ww_collision_o;

    always #5 clk = ~clk;

    ram_nrw_sync #(
        .width_p          (W),
        .els_p            (ELS),
        .ports_p          (P),
        .init_val_p       (INIT_VAL),
        .sim_addr_check_p (1'b0)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .ready_o        (ready_o),
        .v_i            (v_i),
        .w_i            (w_i),
        .addr_i         (addr_i),
        .data_i         (data_i),
        .w_mask_i       (w_mask_i),
        .data_o         (data_o),
        .data_v_o       (data_v_o),
        .ww_collision_o (ww_collision_o)
    );

    typedef struct packed {
        int           due;
        logic [P-1:0] v;
        logic [P*W-1:0] d;
        logic         coll;
    } exp_t;

    exp_t           exp_q[$];
    int             checks = 0;
    int             failures = 0;
    int             cyc = 0;
    logic [W-1:0]   mem_m [ELS];
    logic [W-1:0]   hold_m [P];
    logic           ready_m = 1'b0;
    int             cnt_m = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_reqs();
        v_i = '0; w_i = '0; addr_i = '0; data_i = '0; w_mask_i = '0;
    endtask

    task automatic set_req(input int p, input bit wr, input int a,
                           input logic [W-1:0] d, input logic [W-1:0] m);
        v_i[p] = 1'b1;
        w_i[p] = wr;
        addr_i[p*AW +: AW]  = AW'(a);
        data_i[p*W +: W]    = d;
        w_mask_i[p*W +: W]  = m;
    endtask

    task automatic rd(input int p, input int a);
        set_req(p, 1'b0, a, '0, '0);
    endtask

    task automatic wr(input int p, input int a, input logic [W-1:0] d);
        set_req(p, 1'b1, a, d, 32'hFFFFFFFF);
    endtask

    // Drive one cycle with the current inputs: predict, clock, then check.
    task automatic step(input bit rst);
        exp_t         e;
        exp_t         t;
        logic [W-1:0] nm [ELS];
        logic [P-1:0] acc;
        int           a [P];
        reset_i = rst;
        nm = mem_m;
        for (int p = 0; p < P; p++) begin
            a[p]   = int'(addr_i[p*AW +: AW]);
            acc[p] = v_i[p] && ready_m && !rst;
        end
        // Apply the writes one after another in port order to a copy.
        for (int p = 0; p < P; p++) begin
            if (acc[p] && w_i[p] && a[p] < ELS) begin
                nm[a[p]] = (nm[a[p]] & ~w_mask_i[p*W +: W]) | (data_i[p*W +: W] & w_mask_i[p*W +: W]);
            end
        end
        e.due  = cyc + LAT;
        e.v    = acc;
        e.coll = 1'b0;
        for (int p = 0; p < P; p++) begin
            if (acc[p]) hold_m[p] = (a[p] < ELS) ? nm[a[p]] : '0;
            for (int q = p + 1; q < P; q++) begin
                if (acc[p] && acc[q] && w_i[p] && w_i[q] && a[p] < ELS && a[p] == a[q]) e.coll = 1'b1;
            end
        end
        if (rst) begin
            for (int p = 0; p < P; p++) hold_m[p] = '0;
            for (int i = 0; i < exp_q.size(); i++) begin
                t = exp_q[i];
                t.v = '0; t.d = '0; t.coll = 1'b0;
                exp_q[i] = t;
            end
        end
        for (int p = 0; p < P; p++) e.d[p*W +: W] = hold_m[p];
        mem_m = nm;
        exp_q.push_back(e);

        @(posedge clk);
        cyc++;
        if (rst) begin
            ready_m = 1'b0;
            cnt_m   = 0;
        end else if (!ready_m) begin
            mem_m[cnt_m] = INIT_VAL;
            if (cnt_m == ELS - 1) ready_m = 1'b1;
            else cnt_m++;
        end
        #1;
        check_eq($sformatf("ready c%0d", cyc), 32'(ready_o), 32'(ready_m));
        while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            for (int p = 0; p < P; p++) begin
                check_eq($sformatf("p%0d data c%0d", p, cyc), data_o[p*W +: W], e.d[p*W +: W]);
            end
            check_eq($sformatf("data_v c%0d", cyc), 32'(data_v_o), 32'(e.v));
            check_eq($sformatf("ww_coll c%0d", cyc), 32'(ww_collision_o), 32'(e.coll));
        end
        $display("c%0d rst=%0b ready=%0b dv=%b coll=%0b d2=%h d1=%h d0=%h",
                 cyc, rst, ready_o, data_v_o, ww_collision_o,
                 data_o[2*W +: W], data_o[W +: W], data_o[0 +: W]);
    endtask

    initial begin
        int n;
        int a;
        clear_reqs();
        for (int p = 0; p < P; p++) hold_m[p] = '0;
        for (int i = 0; i < ELS; i++) mem_m[i] = '0;

        // Reset: all outputs at zero.
        step(1'b1);
        step(1'b1);

        // Partial sweep with requests that must be ignored.
        for (int i = 0; i < 7; i++) begin
            clear_reqs();
            rd(0, i);
            wr(1, 2, 32'hDEADBEEF);
            step(1'b0);
        end

        // Reset mid-sweep, then time the rise of ready_o.
        clear_reqs();
        step(1'b1);
        n = 0;
        while (ready_o !== 1'b1 && n < 100) begin
            clear_reqs();
            wr(2, 4, 32'h12345678);
            step(1'b0);
            n++;
        end
        check_eq("ready rise cycles", 32'(n), 32'(ELS));

        // Every entry holds the init value (ignored writes left no trace).
        for (int b = 0; b < ELS; b += P) begin
            clear_reqs();
            for (int p = 0; p < P; p++) rd(p, b + p);
            step(1'b0);
        end

        // Masked write followed by a same-cycle merged write and read.
        clear_reqs();
        wr(0, 3, 32'hFFFF0000);
        step(1'b0);
        clear_reqs();
        set_req(1, 1'b1, 3, 32'h00001234, 32'h0000FFFF);
        rd(2, 3);
        step(1'b0);

        // Write-write collision with a same-cycle reader.
        clear_reqs();
        wr(0, 5, 32'h11111111);
        wr(2, 5, 32'h22222222);
        rd(1, 5);
        step(1'b0);
        clear_reqs();
        step(1'b0);

        // Zero-mask write still returns the stored word.
        clear_reqs();
        set_req(0, 1'b1, 3, 32'h0, 32'h0);
        rd(1, 5);
        step(1'b0);

        // Reads beyond the last entry.
        clear_reqs();
        rd(1, ELS);
        rd(0, 15);
        rd(2, 3);
        step(1'b0);

        // Random traffic on a small address window to provoke collisions.
        for (int i = 0; i < 80; i++) begin
            clear_reqs();
            for (int p = 0; p < P; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    if ($urandom_range(0, 1) == 1) begin
                        a = int'($urandom_range(0, 3));
                        set_req(p, 1'b1, a, $urandom, $urandom);
                    end else begin
                        a = int'($urandom_range(0, 15));
                        rd(p, a);
                    end
                end
            end
            step(1'b0);
        end

        clear_reqs();
        repeat (LAT + 1) step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_nrw_sync.md
Name: ram_nrw_sync

Overview:
- Synchronous RAM with a parametrised number of read/write ports (ports_p). It succeeds the fixed two-port read/write RAM.
- Adds per-port bit-masked writes and deterministic collision resolution.
- Same-cycle write-to-read forwarding replaces the undefined-data case.
- After reset, a hardware initialisation sweep brings the array to a known value.
- Used for shared state tables, such as per-flow TCP state, accessed by several pipeline stages.

Parameters:
- width_p, 32, data width in bits.
- els_p, 16, number of entries.
- ports_p, 2, number of read/write ports (1..4).
- addr_width_lp, BSG_SAFE_CLOG2(els_p), derived address width.
- init_val_p, 0, value written to every entry during the init sweep.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- ready_o  out  1  high once the init sweep has finished; requests are accepted only while high.
- v_i  in  ports_p  per-port request valid.
- w_i  in  ports_p  per-port write (1) / read (0).
- addr_i  in  ports_p*addr_width_lp  per-port address.
- data_i  in  ports_p*width_p  per-port write data.
- w_mask_i  in  ports_p*width_p  per-port bit write mask (1 = write this bit).
- data_o  out  ports_p*width_p  per-port read data.
- data_v_o  out  ports_p  per-port read-data valid.
- ww_collision_o  out  1  pulses when two or more ports write the same address in one cycle.

Behaviour:
- Reset values: ready_o=0, data_o=0, data_v_o=0, ww_collision_o=0. Init FSM enters INIT and the sweep counter is set to 0.
- FSM states:
  - INIT: writes init_val_p to entry cnt each cycle, then cnt++. When cnt==els_p-1, the next state is READY.
  - READY: ready_o=1.
- Init timing: with reset_i low at cycle 0, ready_o rises at cycle els_p.
- reset_i asserted in any state, including mid-sweep: synchronous return to INIT with cnt=0. Outputs take their reset values the next cycle.
- Requests while ready_o=0:
  - Ignored: no array update, no read.
  - data_v_o=0 the next cycle.
  - data_o holds its value.
- Accepted request: v_i[p] & ready_o.
- Read latency is 1:
  - Read on port p in cycle t gives data_o[p] and data_v_o[p]=1 in cycle t+1.
  - A write on port p also returns the post-write entry value on data_o[p] in cycle t+1 (write-first), with data_v_o[p]=1.
- data_v_o[p]=0 in any cycle after no accepted request on p; data_o[p] holds its last value.
- Masked write: new = (old & ~mask) | (data & mask). A mask of all zeros leaves the entry unchanged but still returns read data.
- Write-write collision (same address, multiple writes):
  - Masks merge in ascending port order; for overlapping mask bits, the higher port index wins.
  - ww_collision_o=1 in cycle t+1, otherwise 0.
- Write-read collision: a read of an address written in the same cycle returns the fully merged post-write value. Data is never undefined.
- Address >= els_p:
  - Write is ignored.
  - Read returns 0 with data_v_o=1.
  - In simulation only, an $error is issued.
- Storage: behavioural array, ports_p write ports, single clock domain, no clock gating.

Optional Feature:
- Macro: RAM_NRW_SYNC_OUTREG_EN.
- Defined:
  - Adds an output register stage on data_o, data_v_o and ww_collision_o, giving a read latency of 2.
  - The stage resets to 0 and is not stalled.
  - ready_o timing is unchanged.
- Undefined: latency 1 as above.

Decomposition:
- Package ram_nrw_pkg: init FSM state enum (INIT, READY) and a ram_nrw_max_ports_lp constant (4) used for the elaboration check on ports_p.
- Sub-module ram_nrw_init_ctrl: owns the FSM, sweep counter and ready_o; outputs the init write enable and address.
- Top-level ram_nrw_sync: muxes init writes ahead of user writes, plus merge, forwarding and collision logic.

Test Plan (width_p=32, els_p=16, ports_p=3):
- Init sweep: release reset, init_val_p=32'hA5A5A5A5 -> ready_o=0 for cycles 0..15 and 1 at cycle 16; reads of all 16 entries return A5A5A5A5.
- Reset mid-sweep: assert reset_i at cycle 7 for 1 cycle -> ready_o stays 0 and rises 16 cycles after reset deasserts; entries read A5A5A5A5.
- Masked write and forward:
  - Port0 writes addr 3 with data FFFF0000, mask FFFFFFFF.
  - Next cycle, port1 writes addr 3 with data 0000_1234, mask 0000FFFF, while port2 reads addr 3 in the same cycle.
  - Port2 returns FFFF1234 one cycle later.
- Write-write collision: ports 0 and 2 both write addr 5 (11111111 and 22222222, full masks) -> entry = 22222222, ww_collision_o=1 for 1 cycle; both writing ports return 22222222.
- Not-ready and out-of-range:
  - Requests while ready_o=0 -> data_v_o=0, no array change.
  - Read of addr 16+ (address 5'd20 with addr_width_lp=5 is not possible, so use els_p=12) -> read of addr 12 returns 0 with data_v_o=1.
- RAM_NRW_SYNC_OUTREG_EN defined: the same read returns on cycle t+2, with data_v_o low at t+1.
